// File: rtl/updown_count_ctrl_if.sv
// Requester-side handshake bundle for updown_count_ctrl: two valid/ready target ports.
interface updown_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_target;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_target;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_target, req1_valid, req1_target,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_target, req1_valid, req1_target,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/updown_count_ctrl.sv
// Steers an external up/down counter to targets from two round-robin requesters.
// Optional job watchdog enabled by defining CNT_CTRL_TIMEOUT_EN.
module updown_count_ctrl #(
  parameter int WIDTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_count_ctrl_if.slave   req,
  input  logic                 clr,
  output logic                 cnt_up,
  output logic                 cnt_down,
  output logic                 cnt_reset,
  input  logic [WIDTH-1:0]     cnt_value,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] target_r;
  logic             idx_r;
  logic             rr_r;      // 1: req1 has priority on the next contested grant
  logic             grant_s;
  logic             accept_s;
  logic             rdy0_s, rdy1_s;
  logic             up_s, down_s, rst_s;

`ifdef CNT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_flag_r;
  logic          tmo_hit_s;
  logic          tmo_expired_s;

  assign tmo_expired_s = (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));
`endif

  // Next-state, grant and counter-pulse decode; reset suppresses every strobe.
  always_comb begin
    state_s  = state_r;
    grant_s  = 1'b0;
    accept_s = 1'b0;
    rdy0_s   = 1'b0;
    rdy1_s   = 1'b0;
    up_s     = 1'b0;
    down_s   = 1'b0;
    rst_s    = 1'b0;
`ifdef CNT_CTRL_TIMEOUT_EN
    tmo_hit_s = 1'b0;
`endif
    if (reset) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (clr) begin
            rst_s = 1'b1;
          end else if (req.req0_valid || req.req1_valid) begin
            accept_s = 1'b1;
            state_s  = CMP;
            if (req.req0_valid && (!req.req1_valid || !rr_r)) begin
              grant_s = 1'b0;
              rdy0_s  = 1'b1;
            end else begin
              grant_s = 1'b1;
              rdy1_s  = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        CMP: begin
`ifdef CNT_CTRL_TIMEOUT_EN
          if (tmo_expired_s) begin
            state_s   = DONE;
            tmo_hit_s = 1'b1;
          end else
`endif
          if (cnt_value == target_r) begin
            state_s = DONE;
          end else if (cnt_value < target_r) begin
            up_s    = 1'b1;
            state_s = WAIT;
          end else begin
            down_s  = 1'b1;
            state_s = WAIT;
          end
        end
        WAIT: begin
`ifdef CNT_CTRL_TIMEOUT_EN
          if (tmo_expired_s) begin
            state_s   = DONE;
            tmo_hit_s = 1'b1;
          end else
`endif
          begin
            state_s = CMP;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State register plus job context latched at the accepting handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      target_r <= '0;
      idx_r    <= 1'b0;
      rr_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        target_r <= grant_s ? req.req1_target : req.req0_target;
        idx_r    <= grant_s;
        rr_r     <= ~grant_s;
      end else begin
        target_r <= target_r;
        idx_r    <= idx_r;
        rr_r     <= rr_r;
      end
    end
  end

`ifdef CNT_CTRL_TIMEOUT_EN
  // Watchdog counts cycles spent in CMP/WAIT; flag marks a job ended by expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r  <= '0;
      tmo_flag_r <= 1'b0;
    end else if (state_r == IDLE) begin
      tmo_cnt_r  <= '0;
      tmo_flag_r <= 1'b0;
    end else if (state_r == CMP || state_r == WAIT) begin
      tmo_cnt_r  <= tmo_cnt_r + TW'(1);
      tmo_flag_r <= tmo_hit_s;
    end else begin
      tmo_cnt_r  <= tmo_cnt_r;
      tmo_flag_r <= tmo_flag_r;
    end
  end

  assign timeout = (state_r == DONE) && tmo_flag_r;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign timeout        = 1'b0;
`endif

  assign req.req0_ready = rdy0_s;
  assign req.req1_ready = rdy1_s;
  assign cnt_up         = up_s;
  assign cnt_down       = down_s;
  assign cnt_reset      = rst_s;
  assign busy           = (state_r != IDLE);
  assign done           = (state_r == DONE);
  assign done_id        = (state_r == DONE) ? idx_r : 1'b0;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl with a behavioural up/down counter in the loop.
module tb_updown_count_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, clr;
  logic         cnt_up, cnt_down, cnt_reset;
  logic         busy, done, done_id, timeout;
  logic [W-1:0] cnt_q;
  logic         ld_en, freeze;
  logic [W-1:0] ld_val;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  updown_count_ctrl_if #(.WIDTH(W)) bus ();

  updown_count_ctrl #(.WIDTH(W), .TIMEOUT_CYC(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus),
    .clr       (clr),
    .cnt_up    (cnt_up),
    .cnt_down  (cnt_down),
    .cnt_reset (cnt_reset),
    .cnt_value (cnt_q),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .timeout   (timeout)
  );

  // Counter being driven; preloadable and freezable from the bench.
  always @(posedge clk) begin
    if (ld_en)          cnt_q <= ld_val;
    else if (freeze)    cnt_q <= cnt_q;
    else if (cnt_reset) cnt_q <= '0;
    else if (cnt_up)    cnt_q <= cnt_q + 4'd1;
    else if (cnt_down)  cnt_q <= cnt_q - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic run_job(input bit id, input logic [W-1:0] tgt, input int exp_lat,
                         input int exp_up, input int exp_dn, input bit disturb);
    int  lat = 0, ups = 0, dns = 0, rsts = 0, rdys = 0, excl = 0;
    bit  seen = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_target = tgt; end
    else    begin bus.req0_valid = 1'b1; bus.req0_target = tgt; end
    #1;
    chk("accept_ready", 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
    chk("other_ready",  32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
    for (int c = 1; c <= 80 && !seen; c++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      clr            = 1'b0;
      if (disturb) begin
        clr             = 1'b1;
        bus.req1_valid  = 1'b1;
        bus.req1_target = 4'd9;
      end
      #1;
      ups  += int'(cnt_up);
      dns  += int'(cnt_down);
      rsts += int'(cnt_reset);
      rdys += int'(bus.req0_ready | bus.req1_ready);
      if ((int'(cnt_up) + int'(cnt_down) + int'(cnt_reset)) > 1) excl++;
      if (done) begin
        seen = 1'b1;
        lat  = c;
        chk("done_id", 32'(done_id), 32'(id));
        chk("timeout_clear", 32'(timeout), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end
    clr            = 1'b0;
    bus.req1_valid = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("up_pulses", 32'(ups), 32'(exp_up));
    chk("down_pulses", 32'(dns), 32'(exp_dn));
    chk("no_reset_busy", 32'(rsts), 32'd0);
    chk("no_ready_busy", 32'(rdys), 32'd0);
    chk("pulse_exclusive", 32'(excl), 32'd0);
    @(negedge clk);
    #1;
    chk("final_count", 32'(cnt_q), 32'(tgt));
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int g[4];
    int gn, both, back2back, dn;
    bit prev;
    reset = 1'b1; clr = 1'b1; ld_en = 1'b0; ld_val = '0; freeze = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_target = 4'd3;
    bus.req1_valid = 1'b0; bus.req1_target = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_cnt_reset", 32'(cnt_reset), 32'd0);
    chk("rst_pulses", 32'({cnt_up, cnt_down}), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0; clr = 1'b0; bus.req0_valid = 1'b0;

    load(4'd3);  run_job(1'b0, 4'd7, 10, 4, 0, 1'b0);
    load(4'd9);  run_job(1'b1, 4'd2, 16, 0, 7, 1'b0);
    load(4'd5);  run_job(1'b0, 4'd5, 2, 0, 0, 1'b0);
    load(4'd0);  run_job(1'b0, 4'd15, 32, 15, 0, 1'b0);

    // clr beats a simultaneous request; the request lands one cycle later.
    load(4'd6);
    @(negedge clk);
    clr = 1'b1; bus.req0_valid = 1'b1; bus.req0_target = 4'd2;
    #1;
    chk("clr_pulse", 32'(cnt_reset), 32'd1);
    chk("clr_blocks_ready", 32'(bus.req0_ready), 32'd0);
    chk("clr_stays_idle", 32'(busy), 32'd0);
    run_job(1'b0, 4'd2, 6, 2, 0, 1'b0);

    load(4'd1);  run_job(1'b0, 4'd4, 8, 3, 0, 1'b1);

    // Both requesters held valid straight out of reset.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    load(4'd4);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_target = 4'd4;
    bus.req1_valid = 1'b1; bus.req1_target = 4'd4;
    gn = 0; both = 0; back2back = 0; prev = 1'b0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both++;
      if (prev && (bus.req0_ready || bus.req1_ready)) back2back++;
      if ((bus.req0_ready || bus.req1_ready) && gn < 4) begin
        g[gn] = bus.req1_ready ? 1 : 0;
        gn++;
      end
      prev = bus.req0_ready | bus.req1_ready;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("rr_grants", 32'(gn), 32'd4);
    chk("rr_g0", 32'(g[0]), 32'd0);
    chk("rr_g1", 32'(g[1]), 32'd1);
    chk("rr_g2", 32'(g[2]), 32'd0);
    chk("rr_g3", 32'(g[3]), 32'd1);
    chk("rr_both_ready", 32'(both), 32'd0);
    chk("rr_ready_one_cycle", 32'(back2back), 32'd0);
    repeat (4) @(negedge clk);

    // Reset lands during WAIT of a 0 -> 5 job.
    load(4'd0);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_target = 4'd5;
    #1;
    chk("abort_accept", 32'(bus.req0_ready), 32'd1);
    @(negedge clk); bus.req0_valid = 1'b0;
    #1;
    chk("abort_cmp_up", 32'(cnt_up), 32'd1);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("abort_wait_quiet", 32'({cnt_up, cnt_down}), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pulses", 32'({cnt_up, cnt_down, cnt_reset}), 32'd0);
    reset = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      dn += int'(done) + int'(busy);
    end
    chk("abort_no_done", 32'(dn), 32'd0);

`ifdef CNT_CTRL_TIMEOUT_EN
    load(4'd0);
    freeze = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_target = 4'd5;
    dn = 0;
    for (int c = 1; c <= 100 && dn == 0; c++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      if (done) begin
        dn = c;
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_quiet", 32'({cnt_up, cnt_down}), 32'd0);
      end
    end
    chk("tmo_latency", 32'(dn), 32'd65);
    freeze = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
